// File: rtl/ddr_burst_responder_if.sv
// Burst handshake bundle between the DDR cache initiator (master) and the
// burst responder (slave).
interface ddr_burst_responder_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LEN_W  = 10
);
  logic              rd_burst_req;
  logic              wr_burst_req;
  logic [LEN_W-1:0]  rd_burst_len;
  logic [LEN_W-1:0]  wr_burst_len;
  logic [ADDR_W-1:0] rd_burst_addr;
  logic [ADDR_W-1:0] wr_burst_addr;
  logic [DATA_W-1:0] wr_burst_data;
  logic              wr_burst_data_req;
  logic              rd_burst_data_valid;
  logic [DATA_W-1:0] rd_burst_data;
  logic              rd_burst_finish;
  logic              wr_burst_finish;
  logic              busy;

  modport master (
    output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    input  wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );

  modport slave (
    input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
           rd_burst_addr, wr_burst_addr, wr_burst_data,
    output wr_burst_data_req, rd_burst_data_valid, rd_burst_data,
           rd_burst_finish, wr_burst_finish, busy
  );
endinterface

// File: rtl/ddr_burst_responder.sv
// Memory-controller side of the DDR burst handshake backed by an on-chip array.
// Optional macro DDR_BURST_BOUND_CHECK_EN adds a sticky burst_err output.
module ddr_burst_responder #(
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned MEM_ADDR_BITS  = 10,
  parameter int unsigned RD_LATENCY     = 4
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  ddr_burst_responder_if.slave bus
`ifdef DDR_BURST_BOUND_CHECK_EN
  ,
  output logic                 burst_err
`endif
);

  localparam int unsigned LEN_W = 10;
  localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);
  localparam int unsigned CNT_W = (LAT_W > LEN_W) ? LAT_W : LEN_W;
  localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE, WR_BURST, WR_TAIL, WR_FIN, RD_WAIT, RD_BURST, RD_FIN, GAP
  } state_e;

  state_e                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [CNT_W-1:0]          last_beat;
  logic                      accept_wr, accept_rd;
  logic [LEN_W-1:0]          len_q;
  logic [MEM_ADDR_BITS-1:0]  wr_ptr, rd_ptr;
  logic                      cap;
  logic [DDR_DATA_WIDTH-1:0] mem [DEPTH];

  logic                      wr_req_q, rd_valid_q, wr_fin_q, rd_fin_q, busy_q;
  logic [DDR_DATA_WIDTH-1:0] rd_data_q;

  assign last_beat = CNT_W'(len_q) - CNT_W'(1);

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt counts cycles spent in the current counting state and restarts at 0 on exit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_burst_req) begin
          accept_wr = 1'b1;
          state_nxt = (bus.wr_burst_len == '0) ? WR_FIN : WR_BURST;
        end else if (bus.rd_burst_req) begin
          accept_rd = 1'b1;
          state_nxt = (bus.rd_burst_len == '0) ? RD_FIN : RD_WAIT;
        end
      end
      WR_BURST: begin
        if (cnt == last_beat) state_nxt = WR_TAIL;
        else                  cnt_nxt   = cnt + CNT_W'(1);
      end
      WR_TAIL: state_nxt = WR_FIN;
      WR_FIN:  state_nxt = GAP;
      RD_WAIT: begin
        if (cnt == CNT_W'(RD_LATENCY - 1)) state_nxt = RD_BURST;
        else                               cnt_nxt   = cnt + CNT_W'(1);
      end
      RD_BURST: begin
        if (cnt == last_beat) state_nxt = RD_FIN;
        else                  cnt_nxt   = cnt + CNT_W'(1);
      end
      RD_FIN:  state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      wr_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_fin_q   <= 1'b0;
      rd_fin_q   <= 1'b0;
      busy_q     <= 1'b0;
      rd_data_q  <= '0;
      cap        <= 1'b0;
      len_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      wr_req_q   <= (state_nxt == WR_BURST);
      rd_valid_q <= (state_nxt == RD_BURST);
      wr_fin_q   <= (state_nxt == WR_FIN);
      rd_fin_q   <= (state_nxt == RD_FIN);
      busy_q     <= (state_nxt != IDLE);
      cap        <= wr_req_q;
      rd_data_q  <= '0;
      if (accept_wr) begin
        len_q  <= bus.wr_burst_len;
        wr_ptr <= bus.wr_burst_addr[MEM_ADDR_BITS-1:0];
      end else if (cap) begin
        wr_ptr <= wr_ptr + MEM_ADDR_BITS'(1);
      end
      if (accept_rd) begin
        len_q  <= bus.rd_burst_len;
        rd_ptr <= bus.rd_burst_addr[MEM_ADDR_BITS-1:0];
      end else if (state_nxt == RD_BURST) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + MEM_ADDR_BITS'(1);
      end
    end
  end

  // Initiator registers beat data on req, so capture trails req by one cycle
  always_ff @(posedge mem_clk) begin
    if (!rst && cap) mem[wr_ptr] <= bus.wr_burst_data;
  end

  assign bus.wr_burst_data_req   = wr_req_q;
  assign bus.rd_burst_data_valid = rd_valid_q;
  assign bus.rd_burst_data       = rd_data_q;
  assign bus.wr_burst_finish     = wr_fin_q;
  assign bus.rd_burst_finish     = rd_fin_q;
  assign bus.busy                = busy_q;

`ifdef DDR_BURST_BOUND_CHECK_EN
  logic [DDR_ADDR_WIDTH-1:0] acc_addr;
  logic [LEN_W-1:0]          acc_len;
  logic                      err_c;
  logic                      err_q;

  always_comb begin
    acc_addr = accept_wr ? bus.wr_burst_addr : bus.rd_burst_addr;
    acc_len  = accept_wr ? bus.wr_burst_len  : bus.rd_burst_len;
    err_c    = ((32'(acc_addr[MEM_ADDR_BITS-1:0]) + 32'(acc_len)) > 32'(DEPTH)) ||
               (acc_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_BITS] != '0);
  end

  always_ff @(posedge mem_clk) begin
    if (rst)                                   err_q <= 1'b0;
    else if ((accept_wr || accept_rd) && err_c) err_q <= 1'b1;
  end

  assign burst_err = err_q;
`else
  // Upper address bits are intentionally ignored when bound checking is off
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.wr_burst_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_BITS],
                              bus.rd_burst_addr[DDR_ADDR_WIDTH-1:MEM_ADDR_BITS]};
`endif

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Scoreboard bench for ddr_burst_responder: stimulus pushes expected events,
// a negedge monitor pops and compares every DUT output event.
module tb_ddr_burst_responder;
  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 28;
  localparam int unsigned MAB   = 10;
  localparam int unsigned LAT   = 4;
  localparam int unsigned LEN_W = 10;

  typedef enum {EV_WREQ, EV_WFIN, EV_RBEAT, EV_RFIN} ev_e;
  typedef struct {
    ev_e           kind;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  logic mem_clk = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  logic prev_req = 1'b0;

  ev_t           sb[$];
  logic [DW-1:0] wbeats[$];
  logic [DW-1:0] model [1024];

  always #5 mem_clk = ~mem_clk;
  always @(posedge mem_clk) cyc <= cyc + 1;

  ddr_burst_responder_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LEN_W)) bus ();

`ifdef DDR_BURST_BOUND_CHECK_EN
  logic burst_err;
`endif

  ddr_burst_responder #(
    .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .MEM_ADDR_BITS(MAB), .RD_LATENCY(LAT)
  ) dut (
    .mem_clk(mem_clk),
    .rst(rst),
    .bus(bus)
`ifdef DDR_BURST_BOUND_CHECK_EN
    ,
    .burst_err(burst_err)
`endif
  );

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_ev(input ev_e k, input logic [DW-1:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected %s data %h at cyc %0d", k.name(), d, cyc);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.cyc != cyc || e.data !== d) begin
      n_err++;
      $display("FAIL event: got %s cyc %0d data %h, required %s cyc %0d data %h",
               k.name(), cyc, d, e.kind.name(), e.cyc, e.data);
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge mem_clk);
      if (bus.wr_burst_data_req)   chk_ev(EV_WREQ, '0);
      if (bus.wr_burst_finish)     chk_ev(EV_WFIN, '0);
      if (bus.rd_burst_data_valid) chk_ev(EV_RBEAT, bus.rd_burst_data);
      if (bus.rd_burst_finish)     chk_ev(EV_RFIN, '0);
    end
  end

  // Initiator data register: next beat appears the cycle after each req cycle
  initial begin
    forever begin
      @(negedge mem_clk);
      if (prev_req && wbeats.size() > 0) bus.wr_burst_data = wbeats.pop_front();
      prev_req = bus.wr_burst_data_req;
    end
  end

  function automatic void push_wr(input logic [AW-1:0] addr, input int len,
                                  input logic [DW-1:0] base, input int acc);
    logic [MAB-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = MAB'(addr) + MAB'(k);
      model[a] = base + DW'(k);
      wbeats.push_back(base + DW'(k));
      sb.push_back('{EV_WREQ, '0, acc + k});
    end
    sb.push_back('{EV_WFIN, '0, (len == 0) ? acc : acc + len + 1});
  endfunction

  function automatic void push_rd(input logic [AW-1:0] addr, input int len, input int acc);
    logic [MAB-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = MAB'(addr) + MAB'(k);
      sb.push_back('{EV_RBEAT, model[a], acc + int'(LAT) + k});
    end
    sb.push_back('{EV_RFIN, '0, (len == 0) ? acc : acc + int'(LAT) + len});
  endfunction

  task automatic wait_until(input int target);
    int n = 0;
    while (cyc < target && n < 500) begin
      @(negedge mem_clk);
      n++;
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge mem_clk);
    while ((bus.busy || sb.size() != 0) && n < 300) begin
      @(negedge mem_clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout %s: busy %0b, %0d events pending", tag, bus.busy, sb.size());
      sb.delete();
    end
  endtask

  // Called at a negedge with the DUT idle; acceptance happens at the next posedge
  task automatic do_wr(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] base);
    push_wr(addr, len, base, cyc + 1);
    bus.wr_burst_addr = addr;
    bus.wr_burst_len  = LEN_W'(len);
    bus.wr_burst_req  = 1'b1;
    @(negedge mem_clk);
    bus.wr_burst_req = 1'b0;
    wait_done("write");
  endtask

  task automatic do_rd(input logic [AW-1:0] addr, input int len);
    push_rd(addr, len, cyc + 1);
    bus.rd_burst_addr = addr;
    bus.rd_burst_len  = LEN_W'(len);
    bus.rd_burst_req  = 1'b1;
    @(negedge mem_clk);
    bus.rd_burst_req = 1'b0;
    wait_done("read");
  endtask

  initial begin
    int acc;
    bus.rd_burst_req  = 1'b0;
    bus.wr_burst_req  = 1'b0;
    bus.rd_burst_len  = '0;
    bus.wr_burst_len  = '0;
    bus.rd_burst_addr = '0;
    bus.wr_burst_addr = '0;
    bus.wr_burst_data = '0;

    // Reset state
    repeat (2) @(negedge mem_clk);
    chk("rst_wr_req", DW'(bus.wr_burst_data_req), '0);
    chk("rst_rd_valid", DW'(bus.rd_burst_data_valid), '0);
    chk("rst_rd_data", bus.rd_burst_data, '0);
    chk("rst_finish", DW'({bus.rd_burst_finish, bus.wr_burst_finish}), '0);
    chk("rst_busy", DW'(bus.busy), '0);
`ifdef DDR_BURST_BOUND_CHECK_EN
    chk("rst_burst_err", DW'(burst_err), '0);
`endif
    rst = 1'b0;
    @(negedge mem_clk);

    // Write then read
    do_wr(AW'('h10), 4, DW'('hA0));
    do_rd(AW'('h10), 4);

    // Simultaneous requests: write (len 2) first, read accepted 6 cycles later
    acc = cyc + 1;
    push_wr(AW'('h20), 2, DW'('hB0), acc);
    push_rd(AW'('h20), 2, acc + 6);
    bus.wr_burst_addr = AW'('h20);
    bus.wr_burst_len  = LEN_W'(2);
    bus.rd_burst_addr = AW'('h20);
    bus.rd_burst_len  = LEN_W'(2);
    bus.wr_burst_req  = 1'b1;
    bus.rd_burst_req  = 1'b1;
    @(negedge mem_clk);
    bus.wr_burst_req = 1'b0;
    wait_until(acc + 6);
    bus.rd_burst_req = 1'b0;
    wait_done("simultaneous");

    // Zero-length read and write
    acc = cyc + 1;
    push_rd(AW'('h10), 0, acc);
    bus.rd_burst_addr = AW'('h10);
    bus.rd_burst_len  = '0;
    bus.rd_burst_req  = 1'b1;
    @(negedge mem_clk);
    bus.rd_burst_req = 1'b0;
    @(negedge mem_clk);
    chk("zero_rd_busy_gap", DW'(bus.busy), DW'(1));
    @(negedge mem_clk);
    chk("zero_rd_busy_idle", DW'(bus.busy), '0);
    do_wr(AW'('h30), 0, DW'('hEE));

`ifdef DDR_BURST_BOUND_CHECK_EN
    chk("err_before_wrap", DW'(burst_err), '0);
`endif
    // Wrap at the top of the array
    do_wr(AW'('h3FE), 3, DW'('hC0));
`ifdef DDR_BURST_BOUND_CHECK_EN
    chk("err_after_wrap", DW'(burst_err), DW'(1));
`endif
    do_rd(AW'('h3FE), 3);
    do_rd(AW'('h000), 1);
    // Upper address bits ignored: aliases to 0x010
    do_rd(AW'('h1000010), 1);

    // Reset during beat 2 of a len-8 read
    do_wr(AW'('h40), 8, DW'('hD0));
    acc = cyc + 1;
    push_rd(AW'('h40), 8, acc);
    bus.rd_burst_addr = AW'('h40);
    bus.rd_burst_len  = LEN_W'(8);
    bus.rd_burst_req  = 1'b1;
    @(negedge mem_clk);
    bus.rd_burst_req = 1'b0;
    wait_until(acc + int'(LAT) + 1);
    rst = 1'b1;
    @(negedge mem_clk);
    sb.delete();
    chk("rst_mid_valid", DW'(bus.rd_burst_data_valid), '0);
    chk("rst_mid_data", bus.rd_burst_data, '0);
    chk("rst_mid_finish", DW'(bus.rd_burst_finish), '0);
    chk("rst_mid_busy", DW'(bus.busy), '0);
`ifdef DDR_BURST_BOUND_CHECK_EN
    chk("rst_mid_err", DW'(burst_err), '0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge mem_clk);
    do_wr(AW'('h50), 2, DW'('hF0));
    do_rd(AW'('h50), 2);
    do_rd(AW'('h44), 2);

    // Read requests toggled during a write are ignored
    acc = cyc + 1;
    push_wr(AW'('h60), 4, DW'('h70), acc);
    bus.wr_burst_addr = AW'('h60);
    bus.wr_burst_len  = LEN_W'(4);
    bus.rd_burst_addr = AW'('h60);
    bus.rd_burst_len  = LEN_W'(4);
    bus.wr_burst_req  = 1'b1;
    @(negedge mem_clk);
    bus.wr_burst_req = 1'b0;
    bus.rd_burst_req = 1'b1;
    wait_until(acc + 2);
    bus.rd_burst_req = 1'b0;
    wait_until(acc + 3);
    bus.rd_burst_req = 1'b1;
    wait_until(acc + 5);
    bus.rd_burst_req = 1'b0;
    wait_until(acc + 9);
    chk("gate_rd_valid", DW'(bus.rd_burst_data_valid), '0);
    chk("gate_busy", DW'(bus.busy), '0);
    wait_done("gating");
    do_rd(AW'('h60), 4);

    repeat (3) @(negedge mem_clk);
    chk("sb_empty", DW'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_burst_responder.md
Name: ddr_burst_responder

Overview:
- Responder (memory-controller side) of the burst handshake driven by the DDR cache interface: accepts read/write burst requests, sequences `wr_burst_data_req` / `rd_burst_data_valid` beats and finish pulses, and backs them with an internal word-addressed memory array.
- Used as the DDR controller stand-in for simulation and on-chip BRAM builds of the associative processor.

Parameters:
- DDR_DATA_WIDTH, 128, width of one burst beat.
- DDR_ADDR_WIDTH, 28, width of burst start addresses.
- MEM_ADDR_BITS, 10, index bits of the backing array; depth = 2^MEM_ADDR_BITS words.
- RD_LATENCY, 4, cycles from read acceptance to first valid beat; legal range ≥1.

Ports:
- mem_clk  in  1  clock.
- rst  in  1  reset.
- rd_burst_req  in  1  read request, level.
- wr_burst_req  in  1  write request, level.
- rd_burst_len  in  10  read beats.
- wr_burst_len  in  10  write beats.
- rd_burst_addr  in  DDR_ADDR_WIDTH  read start word address.
- wr_burst_addr  in  DDR_ADDR_WIDTH  write start word address.
- wr_burst_data  in  DDR_DATA_WIDTH  write beat data.
- wr_burst_data_req  out  1  request for one write beat.
- rd_burst_data_valid  out  1  read beat valid.
- rd_burst_data  out  DDR_DATA_WIDTH  read beat data.
- rd_burst_finish  out  1  one-cycle read-done pulse.
- wr_burst_finish  out  1  one-cycle write-done pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset:
  - Single clock `mem_clk`.
  - `rst` is synchronous and active-high.
  - On reset, state goes to IDLE and all outputs are 0, including `rd_burst_data`. Counters are cleared.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst with no finish pulse. Beats already written stay written.
- States: IDLE, WR_BURST, WR_TAIL, WR_FIN, RD_WAIT, RD_BURST, RD_FIN, GAP.
- IDLE:
  - Samples requests every cycle.
  - If `wr_burst_req` is high, latch `wr_burst_addr`/`wr_burst_len` and go to WR_BURST.
  - Else if `rd_burst_req` is high, latch `rd_burst_addr`/`rd_burst_len` and go to RD_WAIT.
  - Write wins when both requests are high.
  - Requests are ignored in all other states.
- Zero length: a latched len of 0 skips all beats.
  - Write: IDLE→WR_FIN.
  - Read: IDLE→RD_FIN, skipping RD_WAIT.
  - Finish pulse is still issued.
- WR_BURST:
  - `wr_burst_data_req`=1 for exactly len consecutive cycles, then go to WR_TAIL.
- Write data capture:
  - `wr_burst_data` is sampled one cycle after each `wr_burst_data_req` cycle, because the initiator registers data on req.
  - Beat k is written to mem[(addr+k) mod 2^MEM_ADDR_BITS].
  - WR_TAIL captures the last beat, then goes to WR_FIN.
- WR_FIN: `wr_burst_finish`=1 for one cycle, then GAP.
- Write timing: acceptance at cycle T gives req at T+1..T+len, captures at T+2..T+len+1, finish at T+len+2.
- RD_WAIT: counts RD_LATENCY cycles, then goes to RD_BURST.
- RD_BURST:
  - `rd_burst_data_valid`=1 for len consecutive cycles.
  - `rd_burst_data` = mem[(addr+k) mod depth], registered and aligned with valid.
  - Data is 0 when valid is low.
  - Then goes to RD_FIN.
- RD_FIN: `rd_burst_finish`=1 for one cycle, then GAP.
- Read timing: acceptance at T gives first valid at T+1+RD_LATENCY and finish the cycle after the last valid.
- GAP: one cycle, requests ignored, then IDLE. This gives the initiator time to update req/addr/len after finish.
- Address rules:
  - Only addr[MEM_ADDR_BITS-1:0] is used.
  - Beat indexing wraps modulo the depth.
  - Upper address bits are ignored.
- Read-after-write: a read following a completed write observes the written data.

Optional Feature:
- Macro: DDR_BURST_BOUND_CHECK_EN.
- Defined:
  - Adds output `burst_err` (1 bit, reset 0).
  - Set sticky at acceptance when addr[MEM_ADDR_BITS-1:0]+len > 2^MEM_ADDR_BITS, or when any upper address bit is nonzero.
  - Cleared only by `rst`.
  - The burst still executes with wrap.
- Undefined: no `burst_err` port; wrap is silent.

Test Plan:
- Write then read:
  - Stimulus: write len=4 at addr 0x10, data 0xA0..0xA3; then read len=4 at 0x10, RD_LATENCY=4.
  - Required: `wr_burst_data_req` high 4 cycles and `wr_burst_finish` at T+6.
  - Required: read valid at acceptance+5..+8 carrying 0xA0..0xA3, and `rd_burst_finish` the next cycle.
- Simultaneous requests: `wr_burst_req` and `rd_burst_req` high together in IDLE → write served first; read served after GAP.
- Zero length: read len=0 → no valid beats; `rd_burst_finish` pulse 1 cycle after acceptance; `busy` low 2 cycles later.
- Wrap: write len=3 at addr 0x3FE with MEM_ADDR_BITS=10 → data lands at 0x3FE, 0x3FF, 0x000.
  - Macro defined: `burst_err`=1.
  - Macro undefined: no port, same data.
- Reset mid-burst: `rst` asserted during beat 2 of a len=8 read → next cycle `rd_burst_data_valid`=0, no finish pulse, `busy`=0.
  - A new write is then accepted normally.
- Request gating: `rd_burst_req` toggled during an active write → ignored; `rd_burst_data_valid` stays 0 until the write's GAP has passed.
